// File: rtl/hdmi_pipe_ctrl.sv
// Valid/ready flow controller for a chain of clock-enabled pixel delay stages.
// Optional feature: define HDMI_PIPE_BUBBLE_COLLAPSE_EN for per-stage acceptance (bubble compaction).
module hdmi_pipe_ctrl #(
   parameter int STAGES = 4,
   parameter int CW     = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [STAGES-1:0] stage_ce,
   output logic [CW-1:0]     occupancy
);

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] src_v;
   logic [STAGES-1:0] acc;
   logic [CW-1:0]     occ_q, occ_d;

   function automatic logic [CW-1:0] pop_count(input logic [STAGES-1:0] vec);
      logic [CW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < STAGES; i++) begin
         cnt = cnt + CW'(vec[i]);
      end
      return cnt;
   endfunction

   always_comb begin
      src_v    = v_q;
      src_v[0] = in_valid;
      for (int i = 1; i < STAGES; i++) begin
         src_v[i] = v_q[i-1];
      end
   end

`ifdef HDMI_PIPE_BUBBLE_COLLAPSE_EN
   // A stage can load when it is empty or its successor can load; stall ripples back from the output.
   always_comb begin
      acc             = '0;
      acc[STAGES-1]   = ~v_q[STAGES-1] | out_ready;
      for (int i = STAGES - 2; i >= 0; i--) begin
         acc[i] = ~v_q[i] | acc[i+1];
      end
   end
`else
   // Global stall: the whole chain moves only when the last stage can drain or is empty.
   always_comb begin
      acc = {STAGES{out_ready | ~v_q[STAGES-1]}};
   end
`endif

   always_comb begin
      v_d      = v_q;
      stage_ce = '0;
      in_ready = 1'b0;
      if (rst || flush) begin
         v_d = '0;
      end else begin
         in_ready = acc[0];
         stage_ce = acc & src_v;
         for (int i = 0; i < STAGES; i++) begin
            if (acc[i]) begin
               v_d[i] = src_v[i];
            end else begin
               v_d[i] = v_q[i];
            end
         end
      end
      occ_d = pop_count(v_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         occ_q <= '0;
      end else begin
         v_q   <= v_d;
         occ_q <= occ_d;
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_hdmi_pipe_ctrl.sv
// Bench for hdmi_pipe_ctrl: slot-level pipeline model with tagged pixels carried through a
// bench-side data chain clocked by stage_ce; honours HDMI_PIPE_BUBBLE_COLLAPSE_EN like the DUT.
module tb_hdmi_pipe_ctrl;
   localparam int S  = 4;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [S-1:0]  stage_ce;
   logic [CW-1:0] occupancy;

   int total = 0;
   int bad   = 0;
   int tag   = 0;
   int in_data = 0;
   bit chk_en = 1'b0;

   // model: each slot holds a pixel tag, -1 means empty
   int slot[S]  = '{default: -1};
   int nslot[S];
   logic [S-1:0] ce_m;
   logic rdy_m, emit_m;
   int acc_cnt = 0;
   int emit_cnt = 0;

   // data chain exactly as the instantiating level would wire it
   int d[S] = '{default: -1};

   hdmi_pipe_ctrl #(.STAGES(S), .CW(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .stage_ce(stage_ce), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int i = 0; i < S; i++) begin
         if (stage_ce[i]) d[i] <= (i == 0) ? in_data : d[i-1];
      end
   end

   // Movement of pixels this cycle: walk from the output back toward the input.
   always_comb begin
      bit room;
      bit can;
      nslot = slot;
      ce_m  = '0;
      rdy_m = 1'b0;
      emit_m = 1'b0;
      room = 1'b0;
      can  = 1'b0;
      if (rst || flush) begin
         for (int i = 0; i < S; i++) nslot[i] = -1;
      end else begin
         emit_m = (slot[S-1] >= 0) && out_ready;
         room = out_ready || (slot[S-1] < 0);
         for (int i = S - 1; i >= 0; i--) begin
            can = room;
            if (can) begin
               if (i == 0) begin
                  nslot[0] = in_valid ? in_data : -1;
                  ce_m[0]  = in_valid;
               end else begin
                  nslot[i] = slot[i-1];
                  ce_m[i]  = (slot[i-1] >= 0);
               end
            end
`ifdef HDMI_PIPE_BUBBLE_COLLAPSE_EN
            if (i > 0) room = can || (slot[i-1] < 0);
`endif
         end
         rdy_m = can;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         if (rst || flush) begin
            acc_cnt  = 0;
            emit_cnt = 0;
         end else begin
            if (rdy_m && in_valid) acc_cnt++;
            if (emit_m) emit_cnt++;
         end
         slot = nslot;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("out_valid", int'(out_valid), int'(slot[S-1] >= 0));
            chk("occupancy", int'(occupancy), acc_cnt - emit_cnt);
            chk("in_ready", int'(in_ready), int'(rdy_m));
            chk("stage_ce", int'(stage_ce), int'(ce_m));
            if (slot[S-1] >= 0) chk("out_pixel", d[S-1], slot[S-1]);
         end
      end
   end

   task automatic apply(input bit rs, input bit fl, input bit iv, input bit ordy);
      rst = rs;
      flush = fl;
      in_valid = iv;
      out_ready = ordy;
      tag++;
      in_data = tag;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input bit rs, input bit fl, input bit iv, input bit ordy);
      apply(rs, fl, iv, ordy);
      tick();
   endtask

   initial begin
      int first;
      tick();
      chk_en = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_occupancy", int'(occupancy), 0);
      chk("rst_stage_ce", int'(stage_ce), 0);
      chk("rst_in_ready", int'(in_ready), 0);

      // stream from empty: first output in the 4th cycle after the first accept
      apply(1'b0, 1'b0, 1'b1, 1'b1);
      chk("empty_in_ready", int'(in_ready), 1);
      chk("empty_out_valid", int'(out_valid), 0);
      first = 0;
      for (int n = 1; n <= 8; n++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b1);
         if (out_valid && first == 0) first = n;
      end
      chk("first_out_cycle", first, 4);
      chk("stream_occupancy", int'(occupancy), 4);

      // full stall for three cycles, then release
      apply(1'b0, 1'b0, 1'b1, 1'b0);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_stage_ce", int'(stage_ce), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      tick();
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("stall_occupancy", int'(occupancy), 4);
      for (int n = 0; n < 6; n++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
      for (int n = 0; n < 6; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("drain_occupancy", int'(occupancy), 0);

      // gapped input against a stalled output
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("bubble_occupancy", int'(occupancy), 2);
      chk("bubble_out_valid", int'(out_valid), 1);
      apply(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef HDMI_PIPE_BUBBLE_COLLAPSE_EN
      chk("bubble_in_ready", int'(in_ready), 1);
      chk("bubble_stage_ce", int'(stage_ce), 1);
`else
      chk("bubble_in_ready", int'(in_ready), 0);
      chk("bubble_stage_ce", int'(stage_ce), 0);
`endif
      for (int n = 0; n < 6; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // flush with occupancy 3 while a pixel is offered
      for (int n = 0; n < 3; n++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
      chk("preflush_occupancy", int'(occupancy), 3);
      apply(1'b0, 1'b1, 1'b1, 1'b1);
      chk("flush_in_ready", int'(in_ready), 0);
      chk("flush_stage_ce", int'(stage_ce), 0);
      tick();
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      chk("postflush_occupancy", int'(occupancy), 0);
      chk("postflush_out_valid", int'(out_valid), 0);
      chk("postflush_in_ready", int'(in_ready), 1);
      for (int n = 0; n < 6; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // reset while full and stalled; a pulse between edges must not disturb state
      for (int n = 0; n < 6; n++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      tick();
      chk("pulse_occupancy", int'(occupancy), 4);
      chk("pulse_out_valid", int'(out_valid), 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("midrst_occupancy", int'(occupancy), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_stage_ce", int'(stage_ce), 0);
      apply(1'b0, 1'b0, 1'b0, 1'b0);
      chk("midrst_in_ready", int'(in_ready), 1);

      // random traffic with occasional flush
      for (int n = 0; n < 3000; n++) begin
         cyc(1'b0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0);
      end
      for (int n = 0; n < 8; n++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("final_occupancy", int'(occupancy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
